// File: rtl/amba_3_apb.sv
// APB slave with a 256x8 register memory and programmable ACCESS wait states.
// Protocol errors (psel/penable dropped in ACCESS) abort the transfer and raise pslverr for one cycle.
//
// state  | meaning
// IDLE   | no transfer; psel samples wait_count and starts SETUP
// SETUP  | address phase; reads fetch mem[paddr] on exit
// ACCESS | counts down wait_left, completes when it reaches 0
// 2'b11  | illegal, recovers to IDLE
module amba_3_apb (
  input  logic       pclk,
  input  logic       preset,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  input  logic [7:0] wait_count,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [1:0] out_state,
  output logic [7:0] wait_left
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SETUP   = 2'b01,
    ACCESS  = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t     state;
  logic [7:0] mem [256];
  logic       bus_ok;
  logic       do_write;

  assign out_state = state;
  assign pready    = (state == ACCESS) && (wait_left == 8'd0);
  assign bus_ok    = psel && penable;
  assign do_write  = pready && bus_ok && pwrite;

  // Memory has no reset so contents survive preset.
  always_ff @(posedge pclk) begin
    if (do_write) mem[paddr] <= pwdata;
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state     <= IDLE;
      wait_left <= 8'd0;
      prdata    <= 8'd0;
      pslverr   <= 1'b0;
    end else begin
      pslverr <= 1'b0;
      case (state)
        IDLE: begin
          if (psel) begin
            state     <= SETUP;
            wait_left <= wait_count;
          end
        end
        SETUP: begin
          state <= ACCESS;
          if (!pwrite) prdata <= mem[paddr];
        end
        ACCESS: begin
          // Bus protocol violation wins over any pending wait states.
          if (!bus_ok) begin
            state     <= IDLE;
            wait_left <= 8'd0;
            pslverr   <= 1'b1;
          end else if (wait_left == 8'd0) begin
            state <= IDLE;
          end else begin
            wait_left <= wait_left - 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          wait_left <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amba_3_apb.sv
// Self-checking bench for amba_3_apb: directed vector table, a mid-ACCESS reset
// sequence, and randomized transfers checked against a transaction-level memory model.
module tb_amba_3_apb;

  logic       pclk = 1'b0;
  logic       preset;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, wait_count;
  logic [7:0] prdata;
  logic       pready, pslverr;
  logic [1:0] out_state;
  logic [7:0] wait_left;

  amba_3_apb dut (
    .pclk       (pclk),
    .preset     (preset),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .wait_count (wait_count),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .out_state  (out_state),
    .wait_left  (wait_left)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit         rst_before;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] wc;
    int         drop;
    bit         b2b;
    bit         chk_rd;
    logic [7:0] rd_exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] model_mem [256];
  logic [7:0] written[$];
  logic [7:0] exp_prdata;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic vec_t mk(bit rb, bit wr, logic [7:0] a, logic [7:0] d, logic [7:0] wc,
                              int drop, bit b2b, bit cr, logic [7:0] re);
    vec_t v;
    v.rst_before = rb; v.wr = wr; v.addr = a; v.data = d; v.wc = wc;
    v.drop = drop; v.b2b = b2b; v.chk_rd = cr; v.rd_exp = re;
    return v;
  endfunction

  // drop: number of good ACCESS edges before penable is pulled low (-1 = never)
  task automatic xfer(input vec_t v);
    int  rem;
    int  n;
    bit  done;
    bit  err;
    psel = 1'b1; penable = 1'b0; pwrite = v.wr;
    paddr = v.addr; pwdata = v.data; wait_count = v.wc;
    tick();
    chk("setup_state", {6'd0, out_state}, 8'd1);
    chk("setup_wait_left", wait_left, v.wc);
    chk("setup_pready", {7'd0, pready}, 8'd0);
    chk("setup_prdata", prdata, exp_prdata);
    wait_count = 8'($urandom);
    penable = 1'b1;
    tick();
    if (!v.wr) exp_prdata = model_mem[v.addr];
    chk("access_state", {6'd0, out_state}, 8'd2);
    chk("access_wait_left", wait_left, v.wc);
    chk("access_pready", {7'd0, pready}, (v.wc == 8'd0) ? 8'd1 : 8'd0);
    chk("access_prdata", prdata, exp_prdata);
    if (v.chk_rd) chk("read_value", prdata, v.rd_exp);
    if (!v.wr) paddr = 8'($urandom);
    rem = int'(v.wc); n = 0; done = 1'b0; err = 1'b0;
    while (!done) begin
      if (n == v.drop) penable = 1'b0;
      tick();
      if (n == v.drop) begin
        chk("err_state", {6'd0, out_state}, 8'd0);
        chk("err_pslverr", {7'd0, pslverr}, 8'd1);
        chk("err_pready", {7'd0, pready}, 8'd0);
        done = 1'b1; err = 1'b1;
      end else if (rem == 0) begin
        if (v.wr) begin
          model_mem[v.addr] = v.data;
          written.push_back(v.addr);
        end
        chk("done_state", {6'd0, out_state}, 8'd0);
        chk("done_pready", {7'd0, pready}, 8'd0);
        chk("done_pslverr", {7'd0, pslverr}, 8'd0);
        chk("done_wait_left", wait_left, 8'd0);
        chk("done_prdata", prdata, exp_prdata);
        done = 1'b1;
      end else begin
        rem--; n++;
        chk("wait_state", {6'd0, out_state}, 8'd2);
        chk("wait_left", wait_left, 8'(rem));
        chk("wait_pready", {7'd0, pready}, (rem == 0) ? 8'd1 : 8'd0);
        chk("wait_pslverr", {7'd0, pslverr}, 8'd0);
      end
    end
    penable = 1'b0;
    if (!v.b2b || err) begin
      psel = 1'b0;
      tick();
      chk("idle_state", {6'd0, out_state}, 8'd0);
      chk("idle_pslverr", {7'd0, pslverr}, 8'd0);
      chk("idle_wait_left", wait_left, 8'd0);
      chk("idle_pready", {7'd0, pready}, 8'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, {6'd0, out_state}, 8'd0);
    chk({tag, "_wait_left"}, wait_left, 8'd0);
    chk({tag, "_prdata"}, prdata, 8'd0);
    chk({tag, "_pslverr"}, {7'd0, pslverr}, 8'd0);
    chk({tag, "_pready"}, {7'd0, pready}, 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [7:0] wc;
    preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'd0; pwdata = 8'd0; wait_count = 8'd0;
    exp_prdata = 8'd0;
    #3;
    check_reset_outputs("por");
    tick();
    tick();
    preset = 1'b1;

    vecs.push_back(mk(0, 1, 8'h11, 8'h22, 8'd0, -1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h15, 8'h51, 8'd3, -1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'h11, 8'h00, 8'd0, -1, 0, 1, 8'h22));
    vecs.push_back(mk(0, 0, 8'h15, 8'h00, 8'd3, -1, 0, 1, 8'h51));
    vecs.push_back(mk(0, 1, 8'h15, 8'h77, 8'd3,  1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h15, 8'h00, 8'd0, -1, 0, 1, 8'h51));
    vecs.push_back(mk(0, 1, 8'h40, 8'h5A, 8'd1, -1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h40, 8'h00, 8'd0, -1, 1, 1, 8'h5A));
    vecs.push_back(mk(0, 0, 8'h11, 8'h00, 8'd2, -1, 0, 1, 8'h22));

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) begin
        preset = 1'b0;
        #1;
        exp_prdata = 8'd0;
        check_reset_outputs("pulse");
        tick();
        preset = 1'b1;
      end
      xfer(vecs[i]);
    end

    // Reset pulse in the middle of an ACCESS with wait_count=5.
    psel = 1'b1; pwrite = 1'b1; paddr = 8'h15; pwdata = 8'h99; wait_count = 8'd5;
    tick();
    penable = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_abort_wait_left", wait_left, 8'd3);
    #2 preset = 1'b0;
    #1;
    exp_prdata = 8'd0;
    check_reset_outputs("abort");
    psel = 1'b0; penable = 1'b0;
    tick();
    tick();
    preset = 1'b1;
    chk("post_abort_state", {6'd0, out_state}, 8'd0);
    xfer(mk(0, 0, 8'h15, 8'h00, 8'd0, -1, 0, 1, 8'h51));

    for (int i = 0; i < 40; i++) begin
      wc = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 1) == 0 || written.size() == 0)
        v = mk(0, 1, 8'($urandom), 8'($urandom), wc, -1, 0, 0, 8'h00);
      else
        v = mk(0, 0, written[$urandom_range(0, written.size() - 1)], 8'h00, wc, -1, 0, 0, 8'h00);
      if ($urandom_range(0, 4) == 0) v.drop = $urandom_range(0, int'(wc));
      else v.b2b = ($urandom_range(0, 2) == 0);
      xfer(v);
    end

    psel = 1'b0; penable = 1'b0;
    tick();
    chk("final_state", {6'd0, out_state}, 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amba_3_apb.md
AMBA_3_APB -- requirements
Module: amba_3_apb

Interface
REQ-001 One clock; reset is asynchronous and active-low.
REQ-002 pclk  in  1  rising-edge system clock.
REQ-003 preset  in  1  async active-low reset.
REQ-004 psel  in  1  slave select.
REQ-005 penable  in  1  APB enable (ACCESS phase).
REQ-006 pwrite  in  1  1=write, 0=read.
REQ-007 paddr  in  8  byte address into internal memory.
REQ-008 pwdata  in  8  write data.
REQ-009 wait_count  in  8  number of wait cycles to insert in ACCESS before pready.
REQ-010 prdata  out  8  read data.
REQ-011 pready  out  1  transfer-complete strobe.
REQ-012 pslverr  out  1  protocol-error flag.
REQ-013 out_state  out  2  current FSM state encoding.
REQ-014 wait_left  out  8  remaining wait cycles.

Function
REQ-015 Internal storage SHALL be a 256 x 8 memory indexed by paddr; the memory SHALL NOT be cleared by preset.
REQ-016 FSM states SHALL be IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10; 2'b11 is illegal and SHALL return to IDLE on the next edge; out_state SHALL show the state register.
REQ-017 IDLE: psel=1 at a rising edge -> SETUP, loading wait_left <= wait_count; otherwise stay IDLE.
REQ-018 SETUP: next rising edge -> ACCESS unconditionally; on this edge, if pwrite=0, prdata <= mem[paddr].
REQ-019 ACCESS with wait_left>0: wait_left decrements by 1 per edge; state stays ACCESS.
REQ-020 pready SHALL be combinational: 1 exactly when state=ACCESS and wait_left=0, else 0.
REQ-021 ACCESS with wait_left=0 and psel=1, penable=1 at a rising edge: transfer completes; if pwrite=1, mem[paddr] <= pwdata; state -> IDLE.
REQ-022 Wait cycles = wait_count; pready is high for exactly one clock per transfer and falls on the edge that completes it.
REQ-023 ACCESS with psel=0 or penable=0 at any edge: pslverr SHALL be 1 for the following cycle, no memory write, state -> IDLE.
REQ-024 pslverr SHALL be 0 in all other cycles.
REQ-025 prdata SHALL hold its last value outside read SETUP->ACCESS edges; writes SHALL NOT alter prdata.
REQ-026 wait_left SHALL stay 0 in IDLE after completion, never underflow, and not decrement outside ACCESS.
REQ-027 A back-to-back transfer (psel kept high after completion) SHALL start from IDLE: completion edge -> IDLE, next edge -> SETUP.
REQ-028 Address, data, pwrite and wait_count SHALL be sampled only on the edges defined above; changes at other times have no effect.

Reset
REQ-029 preset=0 SHALL immediately, independent of pclk, force state=IDLE, wait_left=0, prdata=0, pslverr=0, pready=0.
REQ-030 Reset asserted mid-transfer (SETUP or ACCESS) SHALL abort it with no memory write; memory contents SHALL be retained.
REQ-031 After preset returns to 1, the first transfer SHALL begin on the first rising edge with psel=1.

Verification
REQ-032 Write, no wait: paddr=0x11, pwdata=0x22, wait_count=0 -> out_state 00->01->10->00; pready high one cycle in ACCESS; mem[0x11]=0x22.
REQ-033 Write, 3 waits: paddr=0x15, pwdata=0x51, wait_count=3 -> ACCESS lasts 4 cycles; wait_left 3,2,1,0; pready only in the last cycle; mem[0x15]=0x51.
REQ-034 Read, no wait after reset: paddr=0x11, wait_count=0 -> prdata=0x22 from ACCESS entry; pready one cycle; memory survives reset.
REQ-035 Read, 3 waits: paddr=0x15, wait_count=3 -> prdata=0x51; pready after 3 wait cycles; wait_left counts 3->0.
REQ-036 Reset pulse mid-ACCESS (wait_count=5): state/outputs reset asynchronously; target address unchanged.
REQ-037 penable dropped during ACCESS waits -> pslverr=1 for one cycle, state returns to IDLE, no write.
